// File: rtl/inv_key_sched.sv
// AES-128 key expansion that stores round keys 0..10 and
// streams them back in reverse order for the decryption datapath.
module inv_key_sched #(
    parameter int NR        = 10,
    parameter int KEY_WIDTH = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_valid,
    output logic                 key_ready,
    input  logic [KEY_WIDTH-1:0] cipher_key,
    input  logic                 replay,
    output logic                 rk_valid,
    input  logic                 rk_ready,
    output logic [KEY_WIDTH-1:0] rk_data,
    output logic [3:0]           rk_index,
    output logic                 rk_last,
    output logic                 busy,
    output logic                 keys_loaded
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXPAND = 2'd1;
    localparam logic [1:0] SERVE  = 2'd2;
    localparam logic [3:0] LAST   = 4'(NR);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [1:0]   state;
    logic [3:0]   cnt;
    logic [127:0] store [0:10];
    logic [127:0] prev;
    logic [127:0] next;
    logic [31:0]  rot;
    logic [31:0]  temp;

    // One expansion step: derive rk[cnt] from rk[cnt-1]
    assign prev = store[4'(cnt - 4'd1)];
    assign rot  = {prev[23:0], prev[31:24]};
    assign temp = {SBOX[rot[31:24]], SBOX[rot[23:16]],
                   SBOX[rot[15:8]],  SBOX[rot[7:0]]}
                ^ {rcon(cnt), 24'h0};

    assign next[127:96] = prev[127:96] ^ temp;
    assign next[95:64]  = prev[95:64]  ^ next[127:96];
    assign next[63:32]  = prev[63:32]  ^ next[95:64];
    assign next[31:0]   = prev[31:0]   ^ next[63:32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            rk_index    <= 4'd0;
            keys_loaded <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        cnt         <= 4'd1;
                        keys_loaded <= 1'b0;
                        state       <= EXPAND;
                    end else if (replay && keys_loaded) begin
                        rk_index <= LAST;
                        state    <= SERVE;
                    end
                end
                EXPAND: begin
                    if (cnt == LAST) begin
                        cnt         <= 4'd0;
                        keys_loaded <= 1'b1;
                        rk_index    <= LAST;
                        state       <= SERVE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                SERVE: begin
                    if (rk_ready) begin
                        if (rk_index == 4'd0)
                            state <= IDLE;
                        else
                            rk_index <= rk_index - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Key store carries no reset; keys_loaded qualifies its contents
    always_ff @(posedge clk) begin
        if (state == IDLE && key_valid)
            store[0] <= cipher_key;
        if (state == EXPAND)
            store[cnt] <= next;
    end

    assign key_ready = rst_n && (state == IDLE);
    assign rk_valid  = (state == SERVE);
    assign busy      = (state != IDLE);
    assign rk_last   = rk_valid && (rk_index == 4'd0);
    assign rk_data   = rk_valid ? store[rk_index] : '0;

endmodule

// File: tb/tb_inv_key_sched.sv
// Bench for inv_key_sched: FIPS-197 schedules served in reverse,
// backpressure, replay, reset abort and key/replay priority.
module tb_inv_key_sched;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] cipher_key = '0;
    logic         replay = 1'b0;
    logic         rk_valid;
    logic         rk_ready = 1'b0;
    logic [127:0] rk_data;
    logic [3:0]   rk_index;
    logic         rk_last;
    logic         busy;
    logic         keys_loaded;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [0:10][127:0] rk;
        logic [6:0]         stall;
    } vec_t;

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] data;
    } beat_t;

    vec_t  vecs [4];
    beat_t q [$];
    logic [0:10][127:0] s_c1;
    logic [0:10][127:0] s_a1;

    inv_key_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .cipher_key  (cipher_key),
        .replay      (replay),
        .rk_valid    (rk_valid),
        .rk_ready    (rk_ready),
        .rk_data     (rk_data),
        .rk_index    (rk_index),
        .rk_last     (rk_last),
        .busy        (busy),
        .keys_loaded (keys_loaded)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sched(input logic [0:10][127:0] s);
        for (int i = 10; i >= 0; i--)
            q.push_back({4'(i), s[i]});
    endtask

    task automatic drain(input logic [6:0] stall, output int cycles);
        int           guard;
        bit           stalled;
        logic [127:0] hold_d;
        logic [3:0]   hold_i;
        beat_t        b;
        guard   = 0;
        stalled = 0;
        hold_d  = '0;
        hold_i  = '0;
        while (q.size() > 0 && guard < 500) begin
            if (stalled) begin
                chk("stall_valid", 128'(rk_valid), 128'd1);
                chk("stall_data", rk_data, hold_d);
                chk("stall_index", 128'(rk_index), 128'(hold_i));
            end
            if (rk_valid)
                chk("serve_key_ready", 128'(key_ready), 128'd0);
            rk_ready = ($urandom_range(99) >= 32'(stall));
            if (rk_valid && rk_ready) begin
                b = q.pop_front();
                chk("beat_index", 128'(rk_index), 128'(b.idx));
                chk("beat_data", rk_data, b.data);
                chk("beat_last", 128'(rk_last), 128'(b.idx == 4'd0));
            end
            stalled = rk_valid && !rk_ready;
            hold_d  = rk_data;
            hold_i  = rk_index;
            step();
            guard++;
        end
        rk_ready = 1'b0;
        cycles   = guard;
        chk("drain_done", 128'(q.size()), 128'd0);
        q.delete();
        chk("post_valid", 128'(rk_valid), 128'd0);
        chk("post_key_ready", 128'(key_ready), 128'd1);
        chk("post_data_zero", rk_data, 128'd0);
        chk("post_loaded", 128'(keys_loaded), 128'd1);
    endtask

    task automatic do_key(input vec_t v, input bit with_replay);
        int lat;
        int cyc;
        chk("accept_ready", 128'(key_ready), 128'd1);
        cipher_key = v.rk[0];
        key_valid  = 1'b1;
        replay     = with_replay;
        step();
        key_valid  = 1'b0;
        replay     = 1'b0;
        push_sched(v.rk);
        chk("expand_busy", 128'(busy), 128'd1);
        chk("expand_key_ready", 128'(key_ready), 128'd0);
        lat = 0;
        while (!rk_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("latency", 128'(lat), 128'd10);
        drain(v.stall, cyc);
        if (v.stall == 0)
            chk("consecutive_beats", 128'(cyc), 128'd11);
    endtask

    initial begin
        int cyc;
        s_c1 = {
            128'h000102030405060708090a0b0c0d0e0f,
            128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
            128'hb692cf0b643dbdf1be9bc5006830b3fe,
            128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
            128'h47f7f7bc95353e03f96c32bcfd058dfd,
            128'h3caaa3e8a99f9deb50f3af57adf622aa,
            128'h5e390f7df7a69296a7553dc10aa31f6b,
            128'h14f9701ae35fe28c440adf4d4ea9c026,
            128'h47438735a41c65b9e016baf4aebf7ad2,
            128'h549932d1f08557681093ed9cbe2c974e,
            128'h13111d7fe3944a17f307a78b4d2b30c5
        };
        s_a1 = {
            128'h2b7e151628aed2a6abf7158809cf4f3c,
            128'ha0fafe1788542cb123a339392a6c7605,
            128'hf2c295f27a96b9435935807a7359f67f,
            128'h3d80477d4716fe3e1e237e446d7a883b,
            128'hef44a541a8525b7fb671253bdb0bad00,
            128'hd4d1c6f87c839d87caf2b8bc11f915bc,
            128'h6d88a37a110b3efddbf98641ca0093fd,
            128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
            128'head27321b58dbad2312bf5607f8d292f,
            128'hac7766f319fadc2128d12941575c006e,
            128'hd014f9a8c9ee2589e13f0cc8b6630ca6
        };
        vecs[0] = {s_c1, 7'd0};
        vecs[1] = {s_a1, 7'd0};
        vecs[2] = {s_a1, 7'd50};
        vecs[3] = {s_c1, 7'd40};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 128'(rk_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_loaded", 128'(keys_loaded), 128'd0);
        chk("rst_index", 128'(rk_index), 128'd0);
        chk("rst_last", 128'(rk_last), 128'd0);
        chk("rst_data", rk_data, 128'd0);
        rst_n = 1'b1;
        step();
        chk("idle_key_ready", 128'(key_ready), 128'd1);

        replay = 1'b1;
        step();
        replay = 1'b0;
        step();
        chk("replay_unloaded", 128'(rk_valid), 128'd0);

        for (int i = 0; i < 4; i++)
            do_key(vecs[i], 1'b0);

        replay = 1'b1;
        step();
        replay = 1'b0;
        chk("replay_valid_next", 128'(rk_valid), 128'd1);
        push_sched(s_c1);
        drain(7'd0, cyc);
        chk("replay_beats", 128'(cyc), 128'd11);

        do_key(vecs[1], 1'b1);

        cipher_key = s_c1[0];
        key_valid  = 1'b1;
        step();
        key_valid  = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_loaded", 128'(keys_loaded), 128'd0);
        chk("abort_valid", 128'(rk_valid), 128'd0);
        chk("abort_data", rk_data, 128'd0);
        step();
        rst_n = 1'b1;
        step();
        replay = 1'b1;
        step();
        replay = 1'b0;
        repeat (2) step();
        chk("replay_after_abort", 128'(rk_valid), 128'd0);

        do_key({s_a1, 7'd30}, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inv_key_sched.md
Name: inv_key_sched

Overview:
- Upstream partner of the final inverse round and the inverse middle rounds in the AES-128 decryption datapath.
- Accepts one 128-bit cipher key and expands it iteratively into round keys 0..10, one round key per cycle, into an internal store.
- Serves the round keys in reverse order (10 down to 0) over a valid/ready stream.
- Round key 0 is the last beat; it feeds the round-10 inverse stage's ip_key.

Parameters:
- NR, 10, number of AES rounds; fixed for AES-128, other values unsupported.
- KEY_WIDTH, 128, cipher/round key width in bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- key_valid  input  1  cipher_key is valid
- key_ready  output  1  block can accept a key
- cipher_key  input  128  AES-128 key; w0 = [127:96], w3 = [31:0]
- replay  input  1  re-serve the stored schedule without re-expansion
- rk_valid  output  1  rk_data is valid
- rk_ready  input  1  consumer accepts rk_data
- rk_data  output  128  round key, same word/byte order as cipher_key
- rk_index  output  4  round number of rk_data (10..0)
- rk_last  output  1  high with rk_index==0
- busy  output  1  state != IDLE
- keys_loaded  output  1  a complete schedule is held

Behaviour:
- Reset (async assert on rst_n low; release synchronous to clk):
  - state=IDLE, round counter=0, keys_loaded=0.
  - Key store is not reset.
  - Output reset values: key_ready=1 while rst_n high and IDLE; rk_valid=0, rk_index=0, rk_last=0, busy=0, rk_data=0.
- FSM has three states: IDLE, EXPAND, SERVE.
- IDLE:
  - key_ready=1, rk_valid=0.
  - key_valid: at that edge, store rk[0]=cipher_key, set cnt=1, clear keys_loaded, go to EXPAND.
  - replay with keys_loaded=1 (and key_valid=0): set rk_index=10, go to SERVE.
  - replay with keys_loaded=0: ignored.
  - key_valid and replay together: key_valid wins.
- EXPAND:
  - key_ready=0.
  - Each edge computes rk[cnt] from rk[cnt-1] and increments cnt:
    - temp = SubWord(RotWord(w3_prev)) ^ {Rcon[cnt],24'h0}
    - w0 = w0_prev ^ temp; w1 = w1_prev ^ w0; w2 = w2_prev ^ w1; w3 = w3_prev ^ w2.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
  - SubWord uses four internal forward S-box lookups, combinational within the cycle.
  - At the edge that writes rk[10]: set keys_loaded=1, rk_index=10, go to SERVE.
  - Latency: accept edge E0; rk_valid is high after edge E10 (10 cycles after acceptance).
- SERVE:
  - rk_valid=1.
  - rk_data = rk[rk_index], a mux from the store driven by the registered index; stable while rk_valid && !rk_ready.
  - rk_last = (rk_index==0).
  - A transfer (rk_valid && rk_ready) with rk_index>0 decrements rk_index.
  - A transfer at rk_index==0 returns to IDLE; rk_valid drops the next cycle.
  - key_valid and replay are ignored in SERVE; key_ready=0.
- rk_valid never deasserts without a transfer, except on reset.
- Back-to-back: the cycle after the final transfer is IDLE with key_ready=1, so a new key can be accepted immediately.
- Reset mid-EXPAND or mid-SERVE: abort immediately, keys_loaded=0; a subsequent replay is ignored until a full expansion completes.
- rk_data is 0 whenever rk_valid=0.

Test Plan:
- Key 000102030405060708090a0b0c0d0e0f, rk_ready=1:
  - rk_valid rises 10 cycles after acceptance.
  - First beat index 10 = 13111d7fe3944a17f307a78b4d2b30c5.
  - Last beat index 0 = the input key, with rk_last=1.
  - 11 beats on consecutive cycles.
- Key 2b7e151628aed2a6abf7158809cf4f3c: round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; round 1 = a0fafe1788542cb123a339392a6c7605.
- Backpressure: rk_ready toggles randomly.
  - rk_data and rk_index hold while stalled.
  - No beat is duplicated or skipped.
  - key_ready stays 0 until after the index-0 transfer.
- Replay after completion: pulse replay in IDLE.
  - Identical 11-beat sequence, with rk_valid high the cycle after replay.
  - replay before any expansion, or after a mid-expansion reset, produces no rk_valid.
- Reset asserted at cnt=5 in EXPAND:
  - Outputs go to reset values asynchronously; keys_loaded=0.
  - A new key then expands correctly.
- key_valid and replay in the same IDLE cycle with keys_loaded=1: the new key is expanded and its schedule is served, not the old one.
